// File: rtl/clave_teclado_pkg.sv
// Shared types and constants for the keypad code-entry block.
package clave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } state_e;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/clave_teclado_if.sv
// Keypad strobes in, authorisation/status out.
interface clave_teclado_if
  import clave_pkg::*;
#(
  parameter int NDIG = 4
);
  localparam int DW = $clog2(NDIG + 1);

  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic               key_enter;
  logic               key_clear;
  logic               clave;
  logic               bloqueo;
  logic               ok;
  logic               fallo;
  logic [DW-1:0]      digitos;

  modport master (
    output key_valid, key_digit, key_enter, key_clear,
    input  clave, bloqueo, ok, fallo, digitos
  );

  modport slave (
    input  key_valid, key_digit, key_enter, key_clear,
    output clave, bloqueo, ok, fallo, digitos
  );

endinterface

// File: rtl/clave_teclado_contador.sv
// Loadable down-counter that stops at zero; zero flag reflects the current count.
module contador_bajada #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clave_teclado.sv
// Keypad code entry: collects BCD digits, checks them on ENTER, toggles clave
// on a match and locks out after MAX_FAIL consecutive wrong codes.
module clave_teclado
  import clave_pkg::*;
#(
  parameter int                      NDIG        = 4,
  parameter logic [DIGIT_W*NDIG-1:0] CODE        = 16'h1234,
  parameter int                      MAX_FAIL    = 3,
  parameter int                      LOCK_CYCLES = 1000,
  parameter int                      TIMEOUT     = 5000,
  parameter logic                    CLAVE_RST   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  clave_teclado_if.slave  kp
);

  localparam int BW   = DIGIT_W * NDIG;
  localparam int DW   = $clog2(NDIG + 1);
  localparam int FW   = (MAX_FAIL > 1) ? $clog2(MAX_FAIL + 1) : 1;
  localparam int TMAX = (LOCK_CYCLES > TIMEOUT) ? LOCK_CYCLES : TIMEOUT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DW-1:0] NDIG_V     = DW'(NDIG);
  localparam logic [FW-1:0] LAST_FAIL  = FW'(MAX_FAIL - 1);
  localparam logic [TW-1:0] TOUT_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 1);

  state_e        state_q;
  logic [BW-1:0] buf_q;
  logic [DW-1:0] dig_q;
  logic          ovf_q;
  logic [FW-1:0] fail_q;
  logic          clave_q;
  logic          bloqueo_q;
  logic          ok_q;
  logic          fallo_q;

  logic          accept_digit;
  logic          match;
  logic          tmr_load_d;
  logic [TW-1:0] tmr_val_d;
  logic          tmr_en_d;
  logic          tmr_zero;

  // A digit only counts when no higher-priority strobe shares its cycle.
  assign accept_digit = kp.key_valid && (kp.key_digit <= BCD_MAX) &&
                        !kp.key_enter && !kp.key_clear;
  assign match        = (dig_q == NDIG_V) && !ovf_q && (buf_q == CODE);

  // One counter serves both the inactivity timeout and the lockout period.
  always_comb begin
    tmr_load_d = 1'b0;
    tmr_val_d  = '0;
    tmr_en_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_digit) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = TOUT_LOAD;
        end
      end
      ENTRY: begin
        if (accept_digit) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = TOUT_LOAD;
        end else if (!kp.key_clear && !kp.key_enter) begin
          tmr_en_d = 1'b1;
        end
      end
      CHECK: begin
        if (!match && (fail_q == LAST_FAIL)) begin
          tmr_load_d = 1'b1;
          tmr_val_d  = LOCK_LOAD;
        end
      end
      LOCKED: tmr_en_d = 1'b1;
      default: ;
    endcase
  end

  contador_bajada #(.WIDTH(TW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_d),
    .load_val (tmr_val_d),
    .en       (tmr_en_d),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      dig_q     <= '0;
      ovf_q     <= 1'b0;
      fail_q    <= '0;
      clave_q   <= CLAVE_RST;
      bloqueo_q <= 1'b0;
      ok_q      <= 1'b0;
      fallo_q   <= 1'b0;
    end else begin
      ok_q    <= 1'b0;
      fallo_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_digit) begin
            buf_q   <= BW'({buf_q, kp.key_digit});
            dig_q   <= DW'(1);
            state_q <= ENTRY;
          end
        end
        ENTRY: begin
          if (kp.key_clear) begin
            buf_q   <= '0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
          end else if (kp.key_enter) begin
            state_q <= CHECK;
          end else if (accept_digit) begin
            buf_q <= BW'({buf_q, kp.key_digit});
            if (dig_q == NDIG_V) ovf_q <= 1'b1;
            else                 dig_q <= dig_q + 1'b1;
          end else if (tmr_zero) begin
            buf_q   <= '0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        CHECK: begin
          buf_q <= '0;
          dig_q <= '0;
          ovf_q <= 1'b0;
          if (match) begin
            clave_q <= ~clave_q;
            ok_q    <= 1'b1;
            fail_q  <= '0;
            state_q <= IDLE;
          end else begin
            fallo_q <= 1'b1;
            fail_q  <= fail_q + 1'b1;
            if (fail_q == LAST_FAIL) begin
              bloqueo_q <= 1'b1;
              state_q   <= LOCKED;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        LOCKED: begin
          if (tmr_zero) begin
            bloqueo_q <= 1'b0;
            fail_q    <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kp.clave   = clave_q;
  assign kp.bloqueo = bloqueo_q;
  assign kp.ok      = ok_q;
  assign kp.fallo   = fallo_q;
  assign kp.digitos = dig_q;

endmodule

// File: tb/tb_clave_teclado.sv
// Directed bench for clave_teclado with short lockout and timeout values.
module tb_clave_teclado;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  clave_teclado_if #(.NDIG(4)) kp ();

  clave_teclado #(
    .NDIG        (4),
    .CODE        (16'h1234),
    .MAX_FAIL    (3),
    .LOCK_CYCLES (20),
    .TIMEOUT     (50),
    .CLAVE_RST   (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [3:0] d);
    kp.key_digit = d;
    kp.key_valid = 1'b1;
    @(negedge clk);
    kp.key_valid = 1'b0;
  endtask

  task automatic code4(input logic [3:0] a, b, c, d);
    key(a); key(b); key(c); key(d);
  endtask

  // Enter strobe; nothing visible in the CHECK cycle, results one cycle later.
  task automatic submit(input string tag, input logic eok, efal, eclave, ebloq);
    kp.key_enter = 1'b1;
    @(negedge clk);
    kp.key_enter = 1'b0;
    chk({tag, "_lat_ok"}, kp.ok, 0);
    chk({tag, "_lat_fallo"}, kp.fallo, 0);
    @(negedge clk);
    chk({tag, "_ok"}, kp.ok, eok);
    chk({tag, "_fallo"}, kp.fallo, efal);
    chk({tag, "_clave"}, kp.clave, eclave);
    chk({tag, "_bloqueo"}, kp.bloqueo, ebloq);
    chk({tag, "_digitos"}, kp.digitos, 0);
  endtask

  task automatic pulse_end(input string tag);
    @(negedge clk);
    chk({tag, "_ok_end"}, kp.ok, 0);
    chk({tag, "_fallo_end"}, kp.fallo, 0);
  endtask

  initial begin
    int  lock_cnt;
    logic saw_pulse;
    rst = 1'b1;
    kp.key_valid = 1'b0;
    kp.key_digit = 4'd0;
    kp.key_enter = 1'b0;
    kp.key_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_clave", kp.clave, 1);
    chk("rst_bloqueo", kp.bloqueo, 0);
    chk("rst_ok", kp.ok, 0);
    chk("rst_fallo", kp.fallo, 0);
    chk("rst_digitos", kp.digitos, 0);
    rst = 1'b0;
    @(negedge clk);

    // correct code toggles clave both ways
    code4(1, 2, 3, 4);
    chk("c1_digitos", kp.digitos, 4);
    submit("c1", 1, 0, 0, 0);
    pulse_end("c1");
    code4(1, 2, 3, 4);
    submit("c2", 1, 0, 1, 0);

    // wrong code, then correct clears fail count
    code4(1, 2, 3, 5);
    submit("w1", 0, 1, 1, 0);
    pulse_end("w1");
    code4(1, 2, 3, 4);
    submit("c3", 1, 0, 0, 0);
    code4(9, 9, 9, 9);
    submit("w2", 0, 1, 0, 0);
    code4(1, 1, 1, 1);
    submit("w3", 0, 1, 0, 0);
    code4(1, 2, 3, 4);
    submit("c4", 1, 0, 1, 0);

    // three wrong codes -> lockout of exactly 20 cycles
    code4(5, 5, 5, 5);
    submit("l1", 0, 1, 1, 0);
    code4(6, 6, 6, 6);
    submit("l2", 0, 1, 1, 0);
    code4(7, 7, 7, 7);
    submit("l3", 0, 1, 1, 1);
    lock_cnt  = 1;
    saw_pulse = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i < 4) begin
        kp.key_digit = 4'(i + 1);
        kp.key_valid = 1'b1;
      end else if (i == 4) begin
        kp.key_enter = 1'b1;
      end
      @(negedge clk);
      kp.key_valid = 1'b0;
      kp.key_enter = 1'b0;
      if (kp.ok || kp.fallo) saw_pulse = 1'b1;
      if (kp.bloqueo) lock_cnt++;
      else break;
    end
    chk("lock_len", lock_cnt, 20);
    chk("lock_no_pulse", saw_pulse, 0);
    chk("lock_clave", kp.clave, 1);
    chk("lock_digitos", kp.digitos, 0);
    code4(1, 2, 3, 4);
    submit("c5", 1, 0, 0, 0);

    // overflow, clear, ignored non-BCD digit
    code4(1, 2, 3, 4);
    key(5);
    chk("ovf_digitos", kp.digitos, 4);
    submit("ovf", 0, 1, 0, 0);
    key(1); key(2);
    kp.key_clear = 1'b1;
    @(negedge clk);
    kp.key_clear = 1'b0;
    chk("clr_digitos", kp.digitos, 0);
    key(1);
    key(4'hA);
    chk("nbcd_digitos", kp.digitos, 1);
    key(2); key(3); key(4);
    submit("c6", 1, 0, 1, 0);

    // inactivity timeout after exactly 50 idle cycles
    key(1); key(2);
    repeat (49) @(negedge clk);
    chk("tout_49", kp.digitos, 2);
    @(negedge clk);
    chk("tout_50", kp.digitos, 0);
    chk("tout_fallo", kp.fallo, 0);
    kp.key_enter = 1'b1;
    @(negedge clk);
    kp.key_enter = 1'b0;
    @(negedge clk);
    chk("idle_enter_fallo", kp.fallo, 0);
    chk("idle_enter_ok", kp.ok, 0);

    // enter and clear together: clear wins
    key(1); key(2);
    kp.key_enter = 1'b1;
    kp.key_clear = 1'b1;
    @(negedge clk);
    kp.key_enter = 1'b0;
    kp.key_clear = 1'b0;
    chk("ec_digitos", kp.digitos, 0);
    @(negedge clk);
    chk("ec_fallo", kp.fallo, 0);
    chk("ec_ok", kp.ok, 0);
    code4(1, 2, 3, 4);
    submit("c7", 1, 0, 0, 0);

    // reset during LOCKED
    code4(5, 5, 5, 5);
    submit("r1", 0, 1, 0, 0);
    code4(5, 5, 5, 5);
    submit("r2", 0, 1, 0, 0);
    code4(5, 5, 5, 5);
    submit("r3", 0, 1, 0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rl_bloqueo", kp.bloqueo, 0);
    chk("rl_clave", kp.clave, 1);
    chk("rl_fallo", kp.fallo, 0);
    rst = 1'b0;
    @(negedge clk);
    code4(8, 8, 8, 8);
    submit("rl_w1", 0, 1, 1, 0);
    code4(8, 8, 8, 8);
    submit("rl_w2", 0, 1, 1, 0);

    // reset during CHECK of a correct code: no pulse, clave at reset value
    code4(1, 2, 3, 4);
    kp.key_enter = 1'b1;
    @(negedge clk);
    kp.key_enter = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rc_ok", kp.ok, 0);
    chk("rc_clave", kp.clave, 1);
    chk("rc_digitos", kp.digitos, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rc_ok2", kp.ok, 0);
    chk("rc_fallo2", kp.fallo, 0);
    code4(8, 8, 8, 8);
    submit("rc_w1", 0, 1, 1, 0);
    code4(8, 8, 8, 8);
    submit("rc_w2", 0, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
